// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: fetch FSM states, the NOP encoding and the fetch hold-entry layout.
// Contents: fetch_state_t, NOP_INSTR, fetch_entry_t.
// No ports; package only.
package rv32i_types;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// One-entry hold register for an I-cache word that decode could not take yet.
// Ports: i_clk/i_rst, i_load captures {i_pc, i_instr}, i_clear empties; o_entry is the stored entry.
// Registered, no latency beyond one clock; clear wins over load.
module fetch_buffer
  import rv32i_types::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [31:0]  i_pc,
  input  logic [31:0]  i_instr,
  output fetch_entry_t o_entry
);

  fetch_entry_t r_entry;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_entry <= '0;
    end else if (i_load) begin
      r_entry.pc    <= i_pc;
      r_entry.instr <= i_instr;
      r_entry.valid <= 1'b1;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: fetch PC, I-cache request FSM (REQ/HOLD/DRAIN), redirect handling and the IF/ID register.
// Ports: clk/rst; icache_* request/response; MA_stall, bubble, br_miss/br_target, pred/pred_addr in;
// PC_out/instr_out/valid_out (IF/ID) and IF_stall out. Zero-bubble when the cache answers every cycle.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h00000060,
  parameter logic [31:0] NOP_INSTR = rv32i_types::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        icache_read,
  output logic [31:0] icache_address,
  input  logic [31:0] icache_rdata,
  input  logic        icache_resp,
  input  logic        MA_stall,
  input  logic        bubble,
  input  logic        br_miss,
  input  logic [31:0] br_target,
  input  logic        pred,
  input  logic [31:0] pred_addr,
  output logic [31:0] PC_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic        IF_stall
);

  rv32i_types::fetch_state_t r_state, w_state_nxt;
  rv32i_types::fetch_entry_t w_buf;

  logic [31:0] r_fetch_pc, w_fetch_pc_nxt, r_drain_pc, w_target;
  logic [31:0] r_pc_out, r_instr_out, w_avail_pc, w_avail_instr;
  logic        r_valid_out, r_pred_done;
  logic        w_advance, w_bm, w_pt, w_redirect, w_avail, w_ifid_load;
  logic        w_buf_load, w_buf_clear, w_enter_drain;

  assign w_advance  = !MA_stall && !bubble;
  assign w_bm       = br_miss && !MA_stall;
  // A prediction already acted on must not redirect again while decode is stalled on it.
  assign w_pt       = pred && !r_pred_done;
  assign w_redirect = w_bm || w_pt;
  assign w_target   = w_bm ? br_target : pred_addr;
  // br_miss flushes IF/ID even while decode is bubbling.
  assign w_ifid_load = w_bm || w_advance;

  // A usable word is either a fresh response in REQ or the buffered word in HOLD.
  // A response in DRAIN belongs to the abandoned request and never counts.
  assign w_avail = ((r_state == rv32i_types::REQ) && icache_resp) ||
                   ((r_state == rv32i_types::HOLD) && w_buf.valid);
  assign w_avail_pc    = (r_state == rv32i_types::HOLD) ? w_buf.pc    : r_fetch_pc;
  assign w_avail_instr = (r_state == rv32i_types::HOLD) ? w_buf.instr : icache_rdata;

  assign w_buf_load    = (r_state == rv32i_types::REQ) && icache_resp && !w_redirect && !w_advance;
  assign w_buf_clear   = (r_state == rv32i_types::HOLD) && (w_redirect || w_advance);
  // Redirect with a request in flight: the cache must still see the old address until it answers.
  assign w_enter_drain = (r_state == rv32i_types::REQ) && !icache_resp && w_redirect;

  assign icache_read    = !rst && (r_state != rv32i_types::HOLD);
  assign icache_address = (r_state == rv32i_types::DRAIN) ? r_drain_pc : r_fetch_pc;
  assign IF_stall       = !rst && w_advance && !w_redirect && !w_avail;

  fetch_buffer u_buf (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_load  (w_buf_load),
    .i_clear (w_buf_clear),
    .i_pc    (r_fetch_pc),
    .i_instr (icache_rdata),
    .o_entry (w_buf)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    case (r_state)
      rv32i_types::REQ: begin
        if (w_redirect) begin
          w_fetch_pc_nxt = w_target;
          if (!icache_resp) w_state_nxt = rv32i_types::DRAIN;
        end else if (icache_resp) begin
          if (w_advance) w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          else           w_state_nxt    = rv32i_types::HOLD;
        end
      end
      rv32i_types::HOLD: begin
        if (w_redirect) begin
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = rv32i_types::REQ;
        end else if (w_advance) begin
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_state_nxt    = rv32i_types::REQ;
        end
      end
      rv32i_types::DRAIN: begin
        if (w_redirect)  w_fetch_pc_nxt = w_target;
        if (icache_resp) w_state_nxt    = rv32i_types::REQ;
      end
      default: w_state_nxt = rv32i_types::REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= rv32i_types::REQ;
      r_fetch_pc  <= RESET_PC;
      r_drain_pc  <= '0;
      r_pred_done <= 1'b0;
      r_pc_out    <= '0;
      r_instr_out <= NOP_INSTR;
      r_valid_out <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      if (w_enter_drain) r_drain_pc <= r_fetch_pc;

      if (w_ifid_load)  r_pred_done <= 1'b0;
      else if (w_pt)    r_pred_done <= 1'b1;

      // Any redirect that reaches here makes the current word wrong-path; PC_out keeps its last value on NOPs.
      if (w_ifid_load) begin
        if (!w_redirect && w_avail) begin
          r_pc_out    <= w_avail_pc;
          r_instr_out <= w_avail_instr;
          r_valid_out <= 1'b1;
        end else begin
          r_instr_out <= NOP_INSTR;
          r_valid_out <= 1'b0;
        end
      end
    end
  end

  assign PC_out    = r_pc_out;
  assign instr_out = r_instr_out;
  assign valid_out = r_valid_out;

endmodule
